// File: rtl/adder_arb_ctrl_if.sv
// Requester, response and adder-side signal bundle for adder_arb_ctrl.
// The slave modport is the arbiter's view; master is the surrounding system.
`timescale 1ns/1ps
interface adder_arb_ctrl_if;
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_cin;
    logic        req0_bcd;
    logic        req0_ready;

    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_cin;
    logic        req1_bcd;
    logic        req1_ready;

    logic        rsp_valid;
    logic        rsp_id;
    logic [11:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_ready;

    logic [7:0]  add_A;
    logic [7:0]  add_B;
    logic        add_Cin;
    logic        add_Ctrl;
    logic        add_BCDCtrl;
    logic [11:0] add_Sum;
    logic        add_Cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_bcd,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_bcd,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready,
        input  add_A, add_B, add_Cin, add_Ctrl, add_BCDCtrl,
        output add_Sum, add_Cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_bcd,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_bcd,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready,
        output add_A, add_B, add_Cin, add_Ctrl, add_BCDCtrl,
        input  add_Sum, add_Cout
    );
endinterface

// File: rtl/adder_arb_ctrl.sv
// Round-robin arbiter/sequencer for a shared 8-bit adder with BCD output.
// Define ADDER_ARB_CTRL_BCD_EN to honour the requesters' BCD select.
`timescale 1ns/1ps
module adder_arb_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    adder_arb_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

`ifdef ADDER_ARB_CTRL_BCD_EN
    localparam logic [11:0] SUM_MASK = 12'hFFF;
`else
    // Binary-only build: the hundreds digit can never be legitimately non-zero.
    localparam logic [11:0] SUM_MASK = 12'h0FF;
`endif

    logic [1:0] req_valid;
    logic [7:0] req_a [2];
    logic [7:0] req_b [2];
    logic [1:0] req_cin;
    logic [1:0] req_ready;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_cin   = {bus.req1_cin, bus.req0_cin};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;

    state_t      state_reg, state_next;
    logic        rr_reg, rr_next;
    logic [7:0]  a_reg, a_next;
    logic [7:0]  b_reg, b_next;
    logic        cin_reg, cin_next;
    logic        id_reg, id_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [11:0] sum_reg, sum_next;
    logic        cout_reg, cout_next;

    logic grant;
    logic grant_valid;
    logic accept;
    logic drive;

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        grant_valid = |req_valid;
        if (&req_valid) begin
            grant = rr_reg;
        end else begin
            grant = req_valid[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant == 1'(gi));
        end
    endgenerate

    assign accept         = (state_reg == IDLE) && grant_valid;
    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        cin_next   = cin_reg;
        id_next    = id_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    a_next     = req_a[grant];
                    b_next     = req_b[grant];
                    cin_next   = req_cin[grant];
                    id_next    = grant;
                    cnt_next   = 4'd0;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == SETTLE_LAST) begin
                    sum_next   = bus.add_Sum & SUM_MASK;
                    cout_next  = bus.add_Cout;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rr_next    = ~id_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            a_reg     <= 8'h00;
            b_reg     <= 8'h00;
            cin_reg   <= 1'b0;
            id_reg    <= 1'b0;
            cnt_reg   <= 4'd0;
            sum_reg   <= 12'h000;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            cin_reg   <= cin_next;
            id_reg    <= id_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
        end
    end

    assign drive = (state_reg == DRIVE);

`ifdef ADDER_ARB_CTRL_BCD_EN
    logic [1:0] req_bcd;
    logic       bcd_reg, bcd_next;

    assign req_bcd = {bus.req1_bcd, bus.req0_bcd};

    always_comb begin
        bcd_next = bcd_reg;
        if (accept) begin
            bcd_next = req_bcd[grant];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_reg <= 1'b0;
        end else begin
            bcd_reg <= bcd_next;
        end
    end

    assign bus.add_BCDCtrl = drive && bcd_reg;
`else
    logic bcd_unused;
    assign bcd_unused      = bus.req0_bcd | bus.req1_bcd | accept;
    assign bus.add_BCDCtrl = 1'b0;
`endif

    // The adder sees quiet zero operands whenever it is not enabled.
    assign bus.add_Ctrl = ~drive;
    assign bus.add_A    = drive ? a_reg : 8'h00;
    assign bus.add_B    = drive ? b_reg : 8'h00;
    assign bus.add_Cin  = drive && cin_reg;

    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_sum   = sum_reg;
    assign bus.rsp_cout  = cout_reg;
endmodule

// File: tb/tb_adder_arb_ctrl.sv
// Bench for adder_arb_ctrl: behavioural adder model, table of vectors and a
// response scoreboard, plus arbitration, backpressure and reset sequences.
`timescale 1ns/1ps
module tb_adder_arb_ctrl;
    localparam int SETTLE = 4;
`ifdef ADDER_ARB_CTRL_BCD_EN
    localparam logic BCD_ON = 1'b1;
`else
    localparam logic BCD_ON = 1'b0;
`endif

    typedef struct {
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic        bcd;
        logic [11:0] sum;
        logic        cout;
        int          acc_cyc;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    op_t  q0[$];
    op_t  q1[$];
    op_t  rsp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_arb_ctrl_if bus ();
    adder_arb_ctrl_if bus1 ();

    adder_arb_ctrl #(.SETTLE(SETTLE)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    adder_arb_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    // Shared adder: binary sum, or the low 8 sum bits as three BCD digits.
    function automatic logic [12:0] adder_model(input logic [7:0] a, input logic [7:0] b,
                                                input logic cin, input logic bcd, input logic ctrl_n);
        logic [8:0]  s;
        logic [11:0] r;
        int          v;
        s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        v = int'(s[7:0]);
        if (bcd) r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        else     r = {4'h0, s[7:0]};
        if (ctrl_n) return 13'h0ABC;
        return {s[8], r};
    endfunction

    assign {bus.add_Cout, bus.add_Sum} =
        adder_model(bus.add_A, bus.add_B, bus.add_Cin, bus.add_BCDCtrl, bus.add_Ctrl);
    assign {bus1.add_Cout, bus1.add_Sum} =
        adder_model(bus1.add_A, bus1.add_B, bus1.add_Cin, bus1.add_BCDCtrl, bus1.add_Ctrl);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic op_t mk(input logic id, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic bcd, input logic [11:0] sum,
                               input logic cout);
        op_t o;
        o.id = id; o.a = a; o.b = b; o.cin = cin; o.bcd = bcd;
        o.sum = sum; o.cout = cout; o.acc_cyc = 0;
        return o;
    endfunction

    task automatic set_req(input op_t o);
        if (o.id == 1'b0) begin
            bus.req0_a = o.a; bus.req0_b = o.b; bus.req0_cin = o.cin; bus.req0_bcd = o.bcd;
            bus.req0_valid = 1'b1;
            q0.push_back(o);
        end else begin
            bus.req1_a = o.a; bus.req1_b = o.b; bus.req1_cin = o.cin; bus.req1_bcd = o.bcd;
            bus.req1_valid = 1'b1;
            q1.push_back(o);
        end
    endtask

    task automatic clr_req(input logic id);
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
    endtask

    // want: 0 or 1 for a specific requester, 2 for whichever is accepted first.
    task automatic wait_accept(input int want, output logic id, output int c);
        bit got;
        got = 1'b0;
        id  = 1'b0;
        c   = -1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (want != 1 && bus.req0_valid && bus.req0_ready) begin
                got = 1'b1; id = 1'b0; c = cyc;
            end else if (want != 0 && bus.req1_valid && bus.req1_ready) begin
                got = 1'b1; id = 1'b1; c = cyc;
            end
        end
        check("accept_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !bus.rsp_valid)
                done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and per-cycle protocol monitor for the SETTLE=4 instance.
    initial begin : monitor
        op_t         o;
        logic        pv, ph, pid, pcout;
        logic [11:0] psum;
        pv = 1'b0; ph = 1'b0; pid = 1'b0; pcout = 1'b0; psum = 12'h000;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                ph = 1'b0;
            end else begin
                check("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
                if (bus.req0_valid && bus.req0_ready) begin
                    if (q0.size() == 0) fail("accept0", "accept with no stimulus queued");
                    else begin o = q0.pop_front(); o.acc_cyc = cyc; rsp_q.push_back(o); end
                end
                if (bus.req1_valid && bus.req1_ready) begin
                    if (q1.size() == 0) fail("accept1", "accept with no stimulus queued");
                    else begin o = q1.pop_front(); o.acc_cyc = cyc; rsp_q.push_back(o); end
                end
                if (!bus.add_Ctrl) begin
                    if (rsp_q.size() != 1) fail("drive_op", "adder enabled with no single op in flight");
                    else begin
                        o = rsp_q[0];
                        check("drive_a", 32'(bus.add_A), 32'(o.a));
                        check("drive_b", 32'(bus.add_B), 32'(o.b));
                        check("drive_cin", 32'(bus.add_Cin), 32'(o.cin));
                        check("drive_bcd", 32'(bus.add_BCDCtrl), 32'(o.bcd & BCD_ON));
                    end
                end else begin
                    check("quiet_add", 32'({bus.add_A, bus.add_B, bus.add_Cin, bus.add_BCDCtrl}), 32'd0);
                end
                if (bus.rsp_valid && !pv && rsp_q.size() != 0)
                    check("latency", 32'(cyc - rsp_q[0].acc_cyc), 32'(SETTLE + 1));
                if (bus.rsp_valid && pv && !ph) begin
                    check("hold_id", 32'(bus.rsp_id), 32'(pid));
                    check("hold_sum", 32'(bus.rsp_sum), 32'(psum));
                    check("hold_cout", 32'(bus.rsp_cout), 32'(pcout));
                end
                ph = bus.rsp_valid && bus.rsp_ready;
                if (ph) begin
                    if (rsp_q.size() == 0) fail("rsp_unexpected", "response with nothing outstanding");
                    else begin
                        o = rsp_q.pop_front();
                        check("rsp_id", 32'(bus.rsp_id), 32'(o.id));
                        check("rsp_sum", 32'(bus.rsp_sum), 32'(o.sum));
                        check("rsp_cout", 32'(bus.rsp_cout), 32'(o.cout));
                    end
                end
                pv = bus.rsp_valid; pid = bus.rsp_id; psum = bus.rsp_sum; pcout = bus.rsp_cout;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        op_t  vec [8];
        op_t  arb0 [2];
        op_t  arb1 [2];
        int   exp_order [4];
        int   c, prev_c, hs_c, i0, i1;
        logic gid;
        bit   got;

        vec[0] = mk(1'b0, 8'h3C, 8'h05, 1'b0, 1'b0, 12'h041, 1'b0);
        vec[1] = mk(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 12'h000, 1'b1);
        vec[2] = mk(1'b0, 8'h63, 8'h63, 1'b0, 1'b1, BCD_ON ? 12'h198 : 12'h0C6, 1'b0);
        vec[3] = mk(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 12'h001, 1'b1);
        vec[4] = mk(1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 12'h047, 1'b0);
        vec[5] = mk(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, BCD_ON ? 12'h255 : 12'h0FF, 1'b1);
        vec[6] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0);
        vec[7] = mk(1'b1, 8'h99, 8'h01, 1'b0, 1'b1, BCD_ON ? 12'h154 : 12'h09A, 1'b0);
        arb0[0] = mk(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 12'h003, 1'b0);
        arb0[1] = mk(1'b0, 8'h10, 8'h20, 1'b1, 1'b0, 12'h031, 1'b0);
        arb1[0] = mk(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 12'h080, 1'b0);
        arb1[1] = mk(1'b1, 8'hF0, 8'h20, 1'b0, 1'b0, 12'h010, 1'b1);
        exp_order = '{0, 1, 0, 1};

        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0; bus.req0_bcd = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0; bus.req1_bcd = 0;
        bus.rsp_ready = 1;
        bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_cin = 0; bus1.req0_bcd = 0;
        bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_cin = 0; bus1.req1_bcd = 0;
        bus1.rsp_ready = 1;
        rst = 1'b1;
        rst1 = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        check("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        check("rst_add_ctrl", 32'(bus.add_Ctrl), 32'd1);
        check("rst_add_ops", 32'({bus.add_A, bus.add_B, bus.add_Cin, bus.add_BCDCtrl}), 32'd0);
        check("rst1_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("rst1_add_ctrl", 32'(bus1.add_Ctrl), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst1 = 1'b0;

        // SETTLE=1 instance: accept at T, result at T+2
        bus1.req0_a = 8'h3C; bus1.req0_b = 8'h05; bus1.req0_valid = 1'b1;
        @(negedge clk);
        check("s1_accept", 32'(bus1.req0_ready), 32'd1);
        @(posedge clk);
        #1;
        bus1.req0_valid = 1'b0;
        @(negedge clk);
        check("s1_drive_ctrl", 32'(bus1.add_Ctrl), 32'd0);
        check("s1_drive_valid", 32'(bus1.rsp_valid), 32'd0);
        @(negedge clk);
        check("s1_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
        check("s1_rsp_id", 32'(bus1.rsp_id), 32'd0);
        check("s1_rsp_sum", 32'(bus1.rsp_sum), 32'h041);
        check("s1_rsp_cout", 32'(bus1.rsp_cout), 32'd0);
        @(negedge clk);
        check("s1_rsp_done", 32'(bus1.rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Table of single-requester operations
        for (int i = 0; i < 8; i++) begin
            set_req(vec[i]);
            wait_accept(int'(vec[i].id), gid, c);
            clr_req(vec[i].id);
            wait_drain();
        end

        // Backpressure: five RESP cycles with rsp_ready low, req1 waiting
        bus.rsp_ready = 1'b0;
        set_req(mk(1'b0, 8'hAA, 8'h55, 1'b0, 1'b0, 12'h0FF, 1'b0));
        wait_accept(0, gid, c);
        clr_req(1'b0);
        set_req(mk(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b0, 12'h01E, 1'b0));
        got = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
        end
        check("bp_rsp_seen", 32'(got), 32'd1);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_ready0", 32'(bus.req0_ready), 32'd0);
            check("bp_ready1", 32'(bus.req1_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 32'(bus.rsp_valid), 32'd1);
        hs_c = cyc;
        wait_accept(1, gid, c);
        check("bp_next_accept", 32'(c - hs_c), 32'd1);
        clr_req(1'b1);
        wait_drain();

        // Arbitration from reset with both requesters continuously valid
        rst = 1'b1;
        @(posedge clk);
        #1;
        q0.delete(); q1.delete(); rsp_q.delete();
        rst = 1'b0;
        set_req(arb0[0]);
        set_req(arb1[0]);
        i0 = 1;
        i1 = 1;
        prev_c = 0;
        for (int k = 0; k < 4; k++) begin
            wait_accept(2, gid, c);
            check("arb_order", 32'(gid), 32'(exp_order[k]));
            if (k > 0) check("throughput", 32'(c - prev_c), 32'(SETTLE + 2));
            prev_c = c;
            if (gid == 1'b0) begin
                if (i0 < 2) begin set_req(arb0[i0]); i0++; end
                else clr_req(1'b0);
            end else begin
                if (i1 < 2) begin set_req(arb1[i1]); i1++; end
                else clr_req(1'b1);
            end
        end
        wait_drain();

        // Reset on the 2nd DRIVE cycle, with rr left pointing at requester 1
        set_req(mk(1'b0, 8'h05, 8'h05, 1'b0, 1'b0, 12'h00A, 1'b0));
        wait_accept(0, gid, c);
        clr_req(1'b0);
        wait_drain();
        set_req(mk(1'b1, 8'h22, 8'h22, 1'b0, 1'b0, 12'h044, 1'b0));
        wait_accept(1, gid, c);
        clr_req(1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rsp_q.delete();
        @(negedge clk);
        check("abort_add_ctrl", 32'(bus.add_Ctrl), 32'd1);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_add_a", 32'(bus.add_A), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(mk(1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 12'h003, 1'b0));
        set_req(mk(1'b1, 8'hC8, 8'h64, 1'b0, 1'b0, 12'h02C, 1'b1));
        wait_accept(2, gid, c);
        check("rr_after_reset", 32'(gid), 32'd0);
        clr_req(gid);
        wait_accept(2, gid, c);
        clr_req(gid);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_arb_ctrl.md
# adder_arb_ctrl

Two-requester arbiter and sequencer for the shared 8-bit ripple adder with BCD conversion. It accepts operand pairs from two independent requesters over valid/ready handshakes and grants the adder in round-robin order. It drives the adder's operand, carry and active-low enable inputs, holds them for a configurable settle time, then captures the 12-bit sum and carry-out. The captured result is returned on a single tagged response channel.

## Interface
- SETTLE, default 1: cycles the adder inputs are held enabled before capture; legal 1..15.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 offers an operation.
- req0_a, req0_b  in  8 each  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req0_bcd  in  1  requester 0 asks for a BCD result.
- req0_ready  out  1  requester 0 accepted this cycle when high with req0_valid.
- req1_valid, req1_a, req1_b, req1_cin, req1_bcd, req1_ready: same meaning for requester 1.
- rsp_valid  out  1  result available.
- rsp_id  out  1  requester that owns the result.
- rsp_sum  out  12  captured adder Sum.
- rsp_cout  out  1  captured adder Cout.
- rsp_ready  in  1  consumer takes the result.
- add_A, add_B  out  8 each  adder operands.
- add_Cin  out  1  adder carry-in.
- add_Ctrl  out  1  adder enable, active-low.
- add_BCDCtrl  out  1  adder BCD select.
- add_Sum  in  12  adder sum.
- add_Cout  in  1  adder carry-out.

## Operation
- The FSM has three states: IDLE, DRIVE and RESP. Reset enters IDLE.
- **IDLE:**
  - The grant goes to the valid requester. If both are valid, the grant follows the round-robin pointer `rr`; `rr`=0 favours requester 0.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational; at most one ready is high.
  - On accept, latch a, b, cin, bcd and id, clear the settle counter, and go to DRIVE.
- **DRIVE:**
  - add_Ctrl=0. add_A, add_B, add_Cin and add_BCDCtrl come from the latched values.
  - The counter increments each cycle. On the SETTLE-th DRIVE cycle, register add_Sum and add_Cout into rsp_sum/rsp_cout and go to RESP.
- **RESP:**
  - rsp_valid=1. rsp_id, rsp_sum and rsp_cout stay stable until rsp_valid && rsp_ready.
  - On that handshake: `rr` = ~rsp_id, go to IDLE.
  - add_Ctrl=1.
- **Adder outputs outside DRIVE:** add_Ctrl=1, and add_A, add_B, add_Cin and add_BCDCtrl are 0.
- **Request acceptance:** requests are not accepted in DRIVE or RESP. Requester inputs are don't-care unless valid is high in IDLE.
- **Result width:**
  - rsp_sum is add_Sum unmodified; in binary mode the upper 4 bits are 0 as produced by the adder.
  - The adder's BCD path is 3 digits, 0x000..0x255. rsp_cout is the binary carry-out in both modes.
- **Reset mid-operation:** any in-flight operation is discarded with no response. Outputs return to reset values and `rr`=0.

## Timing
- **Reset values:** state=IDLE, `rr`=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, req0_ready/req1_ready follow IDLE logic, add_Ctrl=1, other add_* outputs 0.
- **Latency:**
  - Accept on cycle T.
  - DRIVE occupies T+1..T+SETTLE; capture happens at the end of T+SETTLE.
  - rsp_valid rises at T+SETTLE+1.
- **Throughput:** if rsp_ready is held high, the next accept is at T+SETTLE+2. Throughput is one operation per SETTLE+2 cycles.
- **Simultaneous valids:** exactly one grant, per `rr`. The loser keeps valid high and is granted next.
- **Lone requester:** a lone requester is granted regardless of `rr`.
- **Back-to-back operations:** the same requester may issue back-to-back operations if the other is idle.
- **Response backpressure:** rsp_ready low holds RESP indefinitely; no new accepts occur.

## Configuration
- **ADDER_ARB_CTRL_BCD_EN defined:**
  - add_BCDCtrl is driven from the latched bcd bit during DRIVE.
  - reqN_bcd is honoured.
- **Not defined:**
  - reqN_bcd is ignored and add_BCDCtrl is tied 0.
  - rsp_sum[11:8] is always 0.
  - The bcd latch is not generated.

## Test plan
- **Binary add, SETTLE=1, req0 only:**
  - Stimulus: a=0x3C, b=0x05, cin=0, bcd=0.
  - Required: accept at T; rsp_valid at T+2 with rsp_id=0, rsp_sum=0x041, rsp_cout=0.
- **Carry wrap:**
  - Stimulus: req1 with a=0xFF, b=0x01, cin=0, bcd=0.
  - Required: rsp_id=1, rsp_sum=0x000, rsp_cout=1.
- **BCD (macro defined):**
  - Stimulus: a=0x63, b=0x63, cin=0, bcd=1.
  - Required: rsp_sum=0x198 and add_BCDCtrl=1 during DRIVE.
  - With the macro undefined, the same stimulus gives rsp_sum=0x0C6.
- **Arbitration:**
  - Stimulus: both valid from reset.
  - Required: req0 is served first, then req1, then req0 again. A ready is never high for both in the same cycle.
- **Backpressure:**
  - Stimulus: rsp_ready low for 5 cycles in RESP.
  - Required: rsp_valid, rsp_sum and rsp_id are stable, and both readies stay low. The handshake occurs on the cycle rsp_ready rises.
- **Reset mid-DRIVE, SETTLE=4:**
  - Stimulus: rst=1 on the 2nd DRIVE cycle.
  - Required:
    - The next cycle shows state IDLE, add_Ctrl=1 and rsp_valid=0.
    - No response is ever issued for the aborted operation.
    - `rr`=0, so req0 wins the next contention.
